// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared states, BCD constants and LFSR step for reaction_timer
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    FOUL = 2'd3
  } state_e;

  localparam logic [3:0]  BCD_MAX       = 4'd9;
  localparam logic [3:0]  FOUL_DIGIT    = 4'hF;
  // Galois right-shift form of x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] BCD_ALL_NINE  = 16'h9999;
  // Count value from which one more tick saturates the display
  localparam logic [15:0] BCD_LAST_STEP = 16'h9998;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ LFSR_TAPS;
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade with clear, increment and carry-out
module bcd_digit
  import reaction_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] value_o,
  output logic       carry_o
);

  logic [3:0] value_q, value_d;

  // Clear wins over increment; 9 wraps to 0 and raises carry for the next decade
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = 4'd0;
    end else if (inc_i) begin
      value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
    end
  end

  // Decade register
  always_ff @(posedge clk_i) begin
    if (rst_i) value_q <= 4'd0;
    else       value_q <= value_d;
  end

  assign value_o = value_q;
  assign carry_o = inc_i && (value_q == BCD_MAX);

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction-time game core: random arm delay, GO lamp, BCD tick counter; optional best score via BEST_SCORE_EN
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TICK_HZ         = 1000,
  parameter int unsigned MIN_DELAY_TICKS = 1000,
  parameter int unsigned RAND_BITS       = 11,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       show_best,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       go_led,
  output logic       foul,
  output logic       overflow
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW  = $clog2(MIN_DELAY_TICKS + (2 ** RAND_BITS));
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_e        state_q;
  logic [15:0]   lfsr_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] delay_q;
  logic [DW-1:0] delay_load;
  logic          go_led_q, foul_q, overflow_q;

  logic          tick;
  logic          delay_expire;
  logic          enter_arm, enter_run, run_stop;
  logic          cnt_clr, cnt_inc, reach_max;
  logic [15:0]   count;
  logic [3:0]    carry;
  logic [3:0]    inc_chain;
  logic          show_best_sel;
  logic [15:0]   best_disp;
  logic [15:0]   disp;
  logic          unused_carry;

  assign tick         = (presc_q == PRESC_LAST);
  assign delay_expire = (delay_q <= DW'(1));
  assign delay_load   = DW'(MIN_DELAY_TICKS) + DW'(lfsr_q[RAND_BITS-1:0]);

  // A press always wins over a same-cycle expiry or tick
  assign enter_arm = (state_q == IDLE) && key_press;
  assign enter_run = (state_q == ARM) && !key_press && tick && delay_expire;
  assign run_stop  = (state_q == RUN) && key_press;
  assign cnt_inc   = (state_q == RUN) && !key_press && tick && (count != BCD_ALL_NINE);
  assign reach_max = cnt_inc && (count == BCD_LAST_STEP);
  assign cnt_clr   = enter_run || ((state_q == FOUL) && key_press);

  // Prescaler restarts on ARM/RUN entry so the first tick is a full period away
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (enter_arm || enter_run || tick) presc_d = '0;
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // Free-running LFSR, advances every cycle regardless of state
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end

  // Game FSM with registered lamp and flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      delay_q    <= '0;
      go_led_q   <= 1'b0;
      foul_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_press) begin
            state_q <= ARM;
            delay_q <= delay_load;
          end
        end
        ARM: begin
          if (key_press) begin
            state_q <= FOUL;
            foul_q  <= 1'b1;
          end else if (tick) begin
            if (delay_expire) begin
              state_q    <= RUN;
              go_led_q   <= 1'b1;
              overflow_q <= 1'b0;
            end else begin
              delay_q <= delay_q - DW'(1);
            end
          end
        end
        RUN: begin
          if (key_press) begin
            state_q  <= IDLE;
            go_led_q <= 1'b0;
          end else if (reach_max) begin
            state_q    <= IDLE;
            go_led_q   <= 1'b0;
            overflow_q <= 1'b1;
          end
        end
        FOUL: begin
          if (key_press) begin
            state_q <= IDLE;
            foul_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inc_chain    = {carry[2:0], cnt_inc};
  assign unused_carry = carry[3];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (cnt_clr),
      .inc_i   (inc_chain[i]),
      .value_o (count[4*i +: 4]),
      .carry_o (carry[i])
    );
  end

`ifdef BEST_SCORE_EN
  logic [15:0] best_q;
  logic        best_valid_q;

  // Keep the fastest run stopped by a press; overflows and fouls never qualify
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q       <= BCD_ALL_NINE;
      best_valid_q <= 1'b0;
    end else if (run_stop && (!best_valid_q || (count < best_q))) begin
      best_q       <= count;
      best_valid_q <= 1'b1;
    end
  end

  assign show_best_sel = (state_q == IDLE) && show_best && best_valid_q;
  assign best_disp     = best_q;
`else
  logic unused_best_inputs;
  assign unused_best_inputs = show_best ^ run_stop;
  assign show_best_sel      = 1'b0;
  assign best_disp          = '0;
`endif

  // Display select: foul pattern, then best score, else the live/last count
  always_comb begin
    disp = count;
    if (foul_q)             disp = {4{FOUL_DIGIT}};
    else if (show_best_sel) disp = best_disp;
  end

  assign dig3     = disp[15:12];
  assign dig2     = disp[11:8];
  assign dig1     = disp[7:4];
  assign dig0     = disp[3:0];
  assign go_led   = go_led_q;
  assign foul     = foul_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - randomized self-checking bench for reaction_timer with a cycle-count reference model
module tb_reaction_timer;

  localparam int CLK_HZ    = 300;
  localparam int TICK_HZ   = 100;
  localparam int P         = CLK_HZ / TICK_HZ;
  localparam int MIN_TICKS = 20;
  localparam int RBITS     = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] RMASK = 16'((1 << RBITS) - 1);
`ifdef BEST_SCORE_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_press = 1'b0;
  logic show_best = 1'b0;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic go_led, foul, overflow;
  logic [15:0] dig;

  int n_cmp = 0;
  int n_fail = 0;

  reaction_timer #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .MIN_DELAY_TICKS (MIN_TICKS),
    .RAND_BITS       (RBITS),
    .LFSR_SEED       (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_press (key_press),
    .show_best (show_best),
    .dig3      (dig3),
    .dig2      (dig2),
    .dig1      (dig1),
    .dig0      (dig0),
    .go_led    (go_led),
    .foul      (foul),
    .overflow  (overflow)
  );

  assign dig = {dig3, dig2, dig1, dig0};

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 armed, 2 running, 3 fouled; time kept in raw cycles
  int m_phase, m_k, m_wait, m_result, m_best;
  bit m_ovf, m_best_ok, m_live;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    if (rst) begin
      m_live    <= 1'b1;
      m_phase   <= 0;
      m_k       <= 0;
      m_wait    <= 0;
      m_result  <= 0;
      m_ovf     <= 1'b0;
      m_best    <= 9999;
      m_best_ok <= 1'b0;
      m_lfsr    <= SEED;
    end else if (m_live) begin
      m_lfsr <= lfsr_step(m_lfsr);
      case (m_phase)
        0: if (key_press) begin
             m_phase <= 1;
             m_k     <= 0;
             m_wait  <= (MIN_TICKS + int'(m_lfsr & RMASK)) * P;
           end
        1: if (key_press) m_phase <= 3;
           else if (m_k == m_wait - 1) begin
             m_phase <= 2;
             m_k     <= 0;
             m_ovf   <= 1'b0;
           end else m_k <= m_k + 1;
        2: if (key_press) begin
             m_phase  <= 0;
             m_result <= m_k / P;
             if (!m_best_ok || (m_k / P) < m_best) begin
               m_best    <= m_k / P;
               m_best_ok <= 1'b1;
             end
           end else if ((m_k + 1) / P >= 9999) begin
             m_phase  <= 0;
             m_result <= 9999;
             m_ovf    <= 1'b1;
           end else m_k <= m_k + 1;
        3: if (key_press) begin
             m_phase  <= 0;
             m_result <= 0;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  function automatic logic [15:0] exp_digits(input int ph, input int k, input int res,
                                             input bit sb, input bit bok, input int best);
    if (ph == 3) return 16'hFFFF;
    if (ph == 2) return to_bcd(k / P);
    if (ph == 0 && BEST_ON && sb && bok) return to_bcd(best);
    return to_bcd(res);
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("go_led", 16'(go_led), 16'(m_phase == 2));
      chk("foul", 16'(foul), 16'(m_phase == 3));
      chk("overflow", 16'(overflow), 16'(m_ovf));
      chk("digits", dig, exp_digits(m_phase, m_k, m_result, show_best, m_best_ok, m_best));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press();
    key_press = 1'b1;
    cyc(1);
    key_press = 1'b0;
  endtask

  task automatic wait_go(input logic want, input int budget, input string name);
    int n;
    n = 0;
    while (go_led !== want && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, 16'(go_led), 16'(want));
  endtask

  task automatic timed_run(input int ticks);
    press();
    wait_go(1'b1, 200, "arm_to_go");
    cyc(ticks * P);
    press();
  endtask

  int r;

  initial begin
    // 1: reset
    cyc(2);
    rst = 1'b0;
    chk("t1_digits", dig, 16'h0000);
    chk("t1_go", 16'(go_led), 16'h0);
    chk("t1_foul", 16'(foul), 16'h0);
    chk("t1_ovf", 16'(overflow), 16'h0);

    // 2: timed run of 123 ticks
    timed_run(123);
    chk("t2_digits", dig, 16'h0123);
    chk("t2_go_off", 16'(go_led), 16'h0);

    // 3: early press fouls, next press clears
    press();
    cyc(5 * P);
    press();
    chk("t3_foul", 16'(foul), 16'h1);
    chk("t3_digits_f", dig, 16'hFFFF);
    press();
    chk("t3_foul_off", 16'(foul), 16'h0);
    chk("t3_digits_0", dig, 16'h0000);

    // 4: no press in RUN saturates at 9999
    press();
    wait_go(1'b1, 200, "t4_go_on");
    wait_go(1'b0, 9999 * P + 20, "t4_go_off");
    chk("t4_digits", dig, 16'h9999);
    chk("t4_ovf", 16'(overflow), 16'h1);

    // 5: reset mid-run at 0042, then re-arm
    press();
    wait_go(1'b1, 200, "t5_go_on");
    cyc(42 * P);
    chk("t5_count42", dig, 16'h0042);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_digits", dig, 16'h0000);
    chk("t5_go", 16'(go_led), 16'h0);
    chk("t5_ovf", 16'(overflow), 16'h0);
    timed_run(7);
    chk("t5_rearm", dig, 16'h0007);

    // 6: best score over three runs
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    timed_run(300);
    timed_run(200);
    timed_run(250);
    chk("t6_last", dig, 16'h0250);
    show_best = 1'b1;
    #1;
    chk("t6_show_best", dig, BEST_ON ? 16'h0200 : 16'h0250);
    cyc(2);
    show_best = 1'b0;

    // Random presses, resets and show_best toggles
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end else begin
        press();
      end
      if (r % 5 == 0) show_best = ~show_best;
      cyc(int'($urandom_range(0, 150)));
    end

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
